// File: rtl/kia_transmitter.sv
// PS/2 host-to-device transmitter: takes a command byte over a Wishbone-style port
// and serializes it as start, 8 data bits LSB first, odd parity, stop, then waits for the device ack.
module kia_transmitter #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CW             = 20
) (
    input  logic       CLK_I,
    input  logic       RES_I,
    input  logic       ADR_I,
    input  logic       WE_I,
    input  logic       CYC_I,
    input  logic       STB_I,
    input  logic [7:0] DAT_I,
    output logic       ACK_O,
    output logic [7:0] DAT_O,
    input  logic       C_I,
    input  logic       D_I,
    output logic       C_OE_O,
    output logic       D_OE_O,
    output logic [2:0] dbg_state
);

    // Bus handshake: ACK_O = CYC_I & STB_I, combinational, zero wait states; DAT_O and
    // write side effects belong to the same cycle, writes commit on that rising CLK_I edge.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INHIBIT = 3'd1,
        START   = 3'd2,
        BITS    = 3'd3,
        ACKW    = 3'd4,
        RECOV   = 3'd5
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    idx, idx_nx;
    logic          d_oe, d_oe_nx;
    logic          nack_set;
    logic [7:0]    tx_byte;
    logic          nack, drop;
    logic          c_s1, c_s2, c_prev;
    logic          d_s1, d_s2;
    logic          fall;
    logic          timeout;
    logic          parity;
    logic          bus_wr, wr_data, wr_stat, busy;

    assign bus_wr  = CYC_I & STB_I & WE_I;
    assign wr_data = bus_wr & ADR_I;
    assign wr_stat = bus_wr & ~ADR_I;
    assign busy    = (state != IDLE);
    assign parity  = ~^tx_byte;
    assign fall    = c_prev & ~c_s2;
    assign timeout = ~fall && (cnt == CW'(TIMEOUT_CYCLES - 1));

    assign ACK_O     = CYC_I & STB_I;
    assign DAT_O     = ADR_I ? tx_byte : {5'b0, drop, nack, busy};
    assign C_OE_O    = (state == INHIBIT);
    assign D_OE_O    = d_oe;
    assign dbg_state = state;

    // Pins idle high, so the synchronizers reset to 1 to avoid a phantom falling edge.
    always_ff @(posedge CLK_I or negedge RES_I) begin
        if (!RES_I) begin
            c_s1   <= 1'b1;
            c_s2   <= 1'b1;
            c_prev <= 1'b1;
            d_s1   <= 1'b1;
            d_s2   <= 1'b1;
        end else begin
            c_s1   <= C_I;
            c_s2   <= c_s1;
            c_prev <= c_s2;
            d_s1   <= D_I;
            d_s2   <= d_s1;
        end
    end

    always_ff @(posedge CLK_I or negedge RES_I) begin
        if (!RES_I) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            d_oe  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            d_oe  <= d_oe_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        d_oe_nx  = d_oe;
        nack_set = 1'b0;
        case (state)
            IDLE: begin
                d_oe_nx = 1'b0;
                if (wr_data) begin
                    state_nx = INHIBIT;
                    cnt_nx   = '0;
                end
            end
            INHIBIT: begin
                if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
                    state_nx = START;
                    cnt_nx   = '0;
                    d_oe_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                if (fall) cnt_nx = '0;
                else      cnt_nx = cnt + CW'(1);
                if (timeout) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    d_oe_nx  = 1'b0;
                    nack_set = 1'b1;
                end else begin
                    case (state)
                        START: begin
                            // First device fall: present data bit 0.
                            if (fall) begin
                                state_nx = BITS;
                                d_oe_nx  = ~tx_byte[0];
                                idx_nx   = 4'd1;
                            end
                        end
                        BITS: begin
                            if (fall) begin
                                if (idx <= 4'd7) begin
                                    d_oe_nx = ~tx_byte[idx[2:0]];
                                    idx_nx  = idx + 4'd1;
                                end else if (idx == 4'd8) begin
                                    d_oe_nx = ~parity;
                                    idx_nx  = idx + 4'd1;
                                end else begin
                                    d_oe_nx  = 1'b0;
                                    state_nx = ACKW;
                                end
                            end
                        end
                        ACKW: begin
                            if (fall) begin
                                nack_set = d_s2;
                                state_nx = RECOV;
                            end
                        end
                        RECOV: begin
                            if (c_s2 && d_s2) state_nx = IDLE;
                        end
                        default: state_nx = IDLE;
                    endcase
                end
            end
        endcase
    end

    // Sticky flags: an FSM set in the same cycle as a bus clear takes priority.
    always_ff @(posedge CLK_I or negedge RES_I) begin
        if (!RES_I) begin
            tx_byte <= 8'h00;
            nack    <= 1'b0;
            drop    <= 1'b0;
        end else begin
            if (wr_data && !busy) tx_byte <= DAT_I;
            if (wr_data && busy)        drop <= 1'b1;
            else if (wr_stat && DAT_I[2]) drop <= 1'b0;
            if (nack_set)               nack <= 1'b1;
            else if (wr_stat && DAT_I[1]) nack <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kia_transmitter.sv
// Bench for kia_transmitter: a PS/2 device model clocks frames out of the DUT,
// and a monitor compares each captured frame against the expected-frame queue.
module tb_kia_transmitter;

    localparam int INH  = 20;
    localparam int TMO  = 400;
    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       adr, we, cyc, stb;
    logic [7:0] dat_i;
    logic       ack;
    logic [7:0] dat_o;
    logic       c_oe, d_oe;
    logic [2:0] dbg_state;
    logic       dev_c, dev_d;
    logic       c_line, d_line;

    int checks = 0;
    int errors = 0;
    int dev_falls = 0;

    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];

    assign c_line = ~c_oe & dev_c;
    assign d_line = ~d_oe & dev_d;

    kia_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .CW(20)) dut (
        .CLK_I(clk), .RES_I(rst_n), .ADR_I(adr), .WE_I(we), .CYC_I(cyc), .STB_I(stb),
        .DAT_I(dat_i), .ACK_O(ack), .DAT_O(dat_o), .C_I(c_line), .D_I(d_line),
        .C_OE_O(c_oe), .D_OE_O(d_oe), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line-level frame as the device sees it: data LSB first, odd parity, released stop.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0);
        return {1'b1, par, b};
    endfunction

    task automatic bus_write(input logic a, input logic [7:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_i = d;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic a, input logic [7:0] exp, input string name);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
        #1;
        chk({name, "_ack"}, ack, 1);
        chk(name, dat_o, exp);
        cyc = 1'b0; stb = 1'b0;
    endtask

    // nfalls = 11: full frame with ack; fewer: stop clocking early; 0: never clock.
    task automatic dev_run(input int nfalls, input logic ack_bit);
        int n;
        logic [9:0] bits;
        bits = '0;
        dev_falls = 0;
        n = 0;
        while (!c_oe && n < 200) begin @(negedge clk); n++; end
        chk("inhibit_seen", c_oe, 1);
        n = 0;
        while (c_oe && n < 200) begin n++; @(negedge clk); end
        chk("inhibit_len", n, INH);
        chk("start_bit_oe", d_oe, 1);
        if (nfalls == 0) begin
            n = 0;
            while (d_oe && n < TMO + 100) begin n++; @(negedge clk); end
            chk("timeout_len", n, TMO);
            chk("timeout_c_oe", c_oe, 0);
            chk("timeout_d_oe", d_oe, 0);
            return;
        end
        repeat (HALF) @(negedge clk);
        for (int k = 1; k <= nfalls; k++) begin
            if (k == 11) dev_d = ack_bit;
            dev_c = 1'b0;
            dev_falls = k;
            repeat (HALF) @(negedge clk);
            if (k <= 10) bits[k-1] = d_line;
            dev_c = 1'b1;
            dev_d = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        if (nfalls == 11) obs_q.push_back(bits);
    endtask

    task automatic run_frame(input logic [7:0] b, input logic ack_bit, input logic [7:0] exp_busy);
        exp_q.push_back(frame_of(b));
        bus_write(1'b1, b);
        fork
            dev_run(11, ack_bit);
            bus_read(1'b0, exp_busy, "status_busy");
        join
        repeat (10) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (obs_q.size() > 0) begin
            logic [9:0] o;
            o = obs_q.pop_front();
            if (exp_q.size() == 0) chk("frame_unexpected", o, 10'h0);
            else                   chk("frame", o, exp_q.pop_front());
        end
    end

    initial begin
        logic [7:0] b;
        logic       nk;
        int         n;
        rst_n = 1'b0; adr = 1'b0; we = 1'b0; cyc = 1'b0; stb = 1'b0; dat_i = 8'h00;
        dev_c = 1'b1; dev_d = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_c_oe", c_oe, 0);
        chk("reset_d_oe", d_oe, 0);
        rst_n = 1'b1;
        bus_read(1'b0, 8'h00, "reset_status");
        bus_read(1'b1, 8'h00, "reset_data");

        run_frame(8'hED, 1'b0, 8'h01);
        bus_read(1'b0, 8'h00, "ed_status_after");

        run_frame(8'h00, 1'b1, 8'h01);
        bus_read(1'b0, 8'h02, "nack_status");
        bus_write(1'b0, 8'h02);
        bus_read(1'b0, 8'h00, "nack_cleared");

        exp_q.push_back(frame_of(8'hF4));
        bus_write(1'b1, 8'hF4);
        fork
            dev_run(11, 1'b0);
            begin
                n = 0;
                while (dev_falls < 3 && n < 500) begin @(negedge clk); n++; end
                chk("drop_wait", n < 500, 1);
                bus_write(1'b1, 8'hAA);
                bus_read(1'b0, 8'h05, "drop_status_busy");
            end
        join
        repeat (10) @(negedge clk);
        bus_read(1'b0, 8'h04, "drop_status_after");
        bus_read(1'b1, 8'hF4, "drop_data");
        bus_write(1'b0, 8'h04);
        bus_read(1'b0, 8'h00, "drop_cleared");

        bus_write(1'b1, 8'h55);
        dev_run(0, 1'b0);
        bus_read(1'b0, 8'h02, "timeout_status");
        bus_write(1'b0, 8'h02);

        bus_write(1'b1, 8'h2C);
        dev_run(5, 1'b0);
        chk("bit4_d_oe", d_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_c_oe", c_oe, 0);
        chk("async_d_oe", d_oe, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(1'b0, 8'h00, "post_reset_status");
        bus_read(1'b1, 8'h00, "post_reset_data");
        run_frame(8'hFF, 1'b0, 8'h01);
        bus_read(1'b0, 8'h00, "ff_status_after");

        for (int i = 0; i < 4; i++) begin
            b  = 8'($urandom_range(0, 255));
            nk = 1'($urandom_range(0, 1));
            run_frame(b, nk, 8'h01);
            bus_read(1'b0, nk ? 8'h02 : 8'h00, "rand_status");
            bus_write(1'b0, 8'h02);
            bus_read(1'b1, b, "rand_data");
        end

        repeat (5) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kia_transmitter.md
# kia_transmitter

Host-to-device PS/2 transmitter for the Kestrel keyboard path. It accepts a command byte over a Wishbone-style slave port and serializes it to the keyboard as a PS/2 host-to-device frame: 8 data bits, odd parity, stop bit, device acknowledge. It drives the open-collector clock and data pins through low-enable outputs. It sits beside the KIA receiver on the same physical pins, so the CPU can send keyboard commands (LED set, reset, typematic rate).

## Interface
Parameters:
- INHIBIT_CYCLES, 5000: CLK_I cycles the clock line is held low before the start bit (100 µs at 50 MHz).
- TIMEOUT_CYCLES, 1000000: maximum CLK_I cycles allowed between device clock falling edges before the transfer aborts.
- CW, 20: width of the shared inhibit/timeout counter; must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
- CLK_I  in  1  system clock.
- RES_I  in  1  reset, asynchronous, active-low.
- ADR_I  in  1  register select: 0 = status, 1 = data.
- WE_I  in  1  write enable.
- CYC_I, STB_I  in  1 each  bus cycle and strobe.
- DAT_I  in  8  write data.
- ACK_O  out  1  bus acknowledge.
- DAT_O  out  8  read data.
- C_I  in  1  PS/2 clock pin level.
- D_I  in  1  PS/2 data pin level.
- C_OE_O  out  1  1 = pull PS/2 clock low; 0 = release.
- D_OE_O  out  1  1 = pull PS/2 data low; 0 = release.

## Operation
- Register map:
  - Status (ADR 0) read: {5'b0, DROP, NACK, BUSY}.
  - Status write: each 1 in DAT_I[2:1] clears the matching sticky flag. BUSY is read-only.
  - Data (ADR 1) write: loads the transmit byte and starts a frame when idle. Data read returns the last byte loaded.
- Write to data while BUSY: byte ignored, DROP set.
- C_I and D_I pass through 2-flop synchronizers. A falling edge is defined as a synchronized 1→0 transition of C.
- Parity bit is ~^byte (odd parity).
- States:
  - IDLE: C_OE=0, D_OE=0. A data write goes to INHIBIT with the counter cleared and BUSY=1.
  - INHIBIT: C_OE=1. After INHIBIT_CYCLES go to START.
  - START: D_OE=1 (start bit 0), C_OE=0; counter cleared. The next falling edge goes to BITS with index 0.
  - BITS: on each falling edge, D_OE = ~bit. Sequence is data bits 0..7 (LSB first), then parity, then stop (D_OE=0, line released). After the stop bit go to ACKW.
  - ACKW: at the next falling edge, sample synchronized D. 0 means acknowledged; 1 sets NACK. Go to RECOV.
  - RECOV: wait until synchronized C=1 and D=1, then go to IDLE and BUSY=0.
- Timeout: in START, BITS, ACKW and RECOV, the counter resets on every falling edge. Reaching TIMEOUT_CYCLES releases both lines, sets NACK, clears BUSY and returns to IDLE.

## Timing
- Reset (RES_I=0, async): state IDLE, C_OE_O=0, D_OE_O=0, status 0x00, data register 0x00, counter 0.
- ACK_O = CYC_I & STB_I, combinational: zero-wait-state, single-cycle response. DAT_O is valid in the same cycle.
- Writes take effect at the rising CLK_I edge where CYC_I&STB_I&WE_I. BUSY reads 1 in the very next cycle.
- C_OE_O asserts in the cycle after the accepting write. It deasserts exactly INHIBIT_CYCLES cycles later, in the same cycle D_OE_O asserts.
- D_OE_O updates 3 CLK_I cycles after each physical C_I fall (2 sync stages plus 1 register stage). The device samples on the rising edge, tens of µs later.
- A flag clear written in the same cycle the FSM sets that flag: the set wins.
- Reset mid-frame releases both lines immediately, without waiting for a clock edge.

## Test plan
- Reset, then read ADR 0 → ACK_O=1 in the same cycle, DAT_O=0x00. C_OE_O=0 and D_OE_O=0.
- Write 0xED to ADR 1 with a device model that clocks at 40 µs per bit and acks with D=0 → C held low ≥INHIBIT_CYCLES, then start bit 0. Observed bits LSB-first 1,0,1,1,0,1,1,1; parity 1; stop released. Status reads 0x01 during the frame and 0x00 after RECOV.
- Write 0x00 → data bits all 0, parity 1. Device withholds ack (D=1 at the 11th fall) → status 0x02. Write 0x02 to ADR 0 → status 0x00.
- Write 0xF4, then write 0xAA during BITS → frame still carries 0xF4. Status reads 0x05 during the frame and 0x04 after it completes. ADR 1 reads 0xF4.
- Device never clocks after the start bit → after TIMEOUT_CYCLES both OE outputs are 0 and status is 0x02.
- Assert RES_I low during bit 4 → C_OE_O=0 and D_OE_O=0 asynchronously, status 0x00. A new write of 0xFF then completes normally: parity 1, status 0x00.
